// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: elastic pipeline register built from DEPTH two-entry skid stages in series.
// Each stage registers its own ready (state != FULL), so no combinational ready path runs
// through the chain; sustained throughput is one beat per cycle, capacity is 2*DEPTH beats.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (all stages empty, data registers zero)
//   flush_i      synchronous clear of all stages (data registers untouched)
//   in_valid_i   upstream beat valid
//   in_data_i    upstream data
//   in_ready_o   stage 0 can accept a beat
//   out_valid_o  last stage holds a beat
//   out_data_o   data of the last stage
//   out_ready_i  downstream accepts the beat
//   occ_o        beats held in total (only with PIPE_REG_SKID_OCC_EN defined)
//
// Optional feature macro: PIPE_REG_SKID_OCC_EN adds the occupancy counter output occ_o.
module pipe_reg_skid #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
`ifdef PIPE_REG_SKID_OCC_EN
    ,
    output logic [$clog2(2*DEPTH+1)-1:0] occ_o
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} stage_st_e;

    stage_st_e        state_q [DEPTH];
    stage_st_e        state_d [DEPTH];
    logic [WIDTH-1:0] main_q  [DEPTH];
    logic [WIDTH-1:0] main_d  [DEPTH];
    logic [WIDTH-1:0] skid_q  [DEPTH];
    logic [WIDTH-1:0] skid_d  [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];

    logic [DEPTH-1:0] stg_vld;
    logic [DEPTH-1:0] stg_rdy;
    logic [DEPTH:0]   chain_vld;  // [k] = valid presented to stage k
    logic [DEPTH:0]   chain_rdy;  // [k+1] = ready seen by stage k
    logic [DEPTH-1:0] up_fire;
    logic [DEPTH-1:0] dn_fire;

    // Valid/ready come straight from the state flops only.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stg_vld[k] = (state_q[k] != StEmpty);
            stg_rdy[k] = (state_q[k] != StFull);
        end
    end

    assign chain_vld = {stg_vld, in_valid_i};
    assign chain_rdy = {out_ready_i, stg_rdy};
    assign up_fire   = chain_vld[DEPTH-1:0] & stg_rdy;
    assign dn_fire   = stg_vld & chain_rdy[DEPTH:1];

    always_comb begin
        up_data[0] = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            up_data[k] = main_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            state_d[k] = state_q[k];
            main_d[k]  = main_q[k];
            skid_d[k]  = skid_q[k];
            case (state_q[k])
                StEmpty: begin
                    if (up_fire[k]) begin
                        state_d[k] = StOne;
                        main_d[k]  = up_data[k];
                    end
                end
                StOne: begin
                    if (up_fire[k] && dn_fire[k]) begin
                        main_d[k] = up_data[k];
                    end else if (up_fire[k]) begin
                        state_d[k] = StFull;
                        skid_d[k]  = up_data[k];
                    end else if (dn_fire[k]) begin
                        state_d[k] = StEmpty;
                    end
                end
                StFull: begin
                    if (dn_fire[k]) begin
                        state_d[k] = StOne;
                        main_d[k]  = skid_q[k];
                    end
                end
                default: state_d[k] = StEmpty;
            endcase
            // Flush only empties the stages; any data captured this edge is simply never seen.
            if (flush_i) begin
                state_d[k] = StEmpty;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                state_q[k] <= StEmpty;
                main_q[k]  <= '0;
                skid_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                state_q[k] <= state_d[k];
                main_q[k]  <= main_d[k];
                skid_q[k]  <= skid_d[k];
            end
        end
    end

    assign in_ready_o  = stg_rdy[0];
    assign out_valid_o = stg_vld[DEPTH-1];
    assign out_data_o  = main_q[DEPTH-1];

`ifdef PIPE_REG_SKID_OCC_EN
    logic [$clog2(2*DEPTH+1)-1:0] occ_q;
    logic [$clog2(2*DEPTH+1)-1:0] occ_d;
    logic                         top_in_fire;
    logic                         top_out_fire;

    assign top_in_fire  = in_valid_i & in_ready_o;
    assign top_out_fire = out_valid_o & out_ready_i;

    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (top_in_fire && !top_out_fire) begin
            occ_d = occ_q + 1'b1;
        end else if (!top_in_fire && top_out_fire) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_o = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid (WIDTH=32, DEPTH=2): a driver pushes every accepted
// beat into a FIFO model; an independent monitor pops and compares on each output transfer.
module tb_pipe_reg_skid;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ready_i;
`ifdef PIPE_REG_SKID_OCC_EN
    logic [$clog2(2*DEPTH+1)-1:0] occ_o;
`endif

    pipe_reg_skid #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_ready_i(out_ready_i)
`ifdef PIPE_REG_SKID_OCC_EN
        ,
        .occ_o      (occ_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WIDTH-1:0] exp_q[$];
    bit   mon_en = 1'b0;
    int   acc_cnt;
    int   first_acc_edge;
    int   out_fires;
    int   first_out_cyc;
    int   last_out_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: decide acceptance away from the edge, update the model at the edge.
    task automatic step();
        bit fire;
        bit fl;
        @(negedge clk);
        fire = rst_ni && in_valid_i && in_ready_o && !flush_i;
        fl   = flush_i;
        if (fire) begin
            if (acc_cnt == 0) first_acc_edge = cyc + 1;
            acc_cnt++;
        end
        @(posedge clk);
        if (fl) exp_q.delete();
        else if (fire) exp_q.push_back(in_data_i);
        #1;
    endtask

    // Monitor: compares DUT output against the model front, independent of the driver.
    initial begin
        bit               prev_hold = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        int               starve = 0;
        forever begin
            @(negedge clk);
            if (!rst_ni || !mon_en) begin
                prev_hold = 1'b0;
                starve    = 0;
            end else begin
`ifdef PIPE_REG_SKID_OCC_EN
                check("occ", 32'(occ_o), 32'(exp_q.size()));
`endif
                if (exp_q.size() == 0) check("ready_when_empty", 32'(in_ready_o), 32'd1);
                if (prev_hold) begin
                    check("hold_valid", 32'(out_valid_o), 32'd1);
                    check("hold_data", out_data_o, prev_data);
                end
                if (out_valid_o) begin
                    starve = 0;
                    if (exp_q.size() == 0) begin
                        check("valid_with_model_empty", 32'(out_valid_o), 32'd0);
                    end else begin
                        check("out_data", out_data_o, exp_q[0]);
                        if (out_ready_i && !flush_i) begin
                            void'(exp_q.pop_front());
                            if (out_fires == 0) first_out_cyc = cyc;
                            last_out_cyc = cyc;
                            out_fires++;
                        end
                    end
                end else if (exp_q.size() != 0) begin
                    starve++;
                    if (starve > DEPTH - 1) check("front_beat_latency", 32'(out_valid_o), 32'd1);
                end else begin
                    starve = 0;
                end
                prev_hold = out_valid_o && !out_ready_i && !flush_i;
                prev_data = out_data_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        acc_cnt     = 0;
        out_fires   = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        mon_en = 1'b1;

        // Asynchronous reset mid-cycle with beats held.
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h5000_0000 + i;
            step();
        end
        in_valid_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", out_data_o, 32'd0);
`ifdef PIPE_REG_SKID_OCC_EN
        check("rst_occ", 32'(occ_o), 32'd0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Streaming 1..8 back-to-back.
        out_ready_i = 1'b1;
        acc_cnt = 0;
        out_fires = 0;
        steps = 0;
        while (acc_cnt < 8 && steps < 30) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'(acc_cnt + 1);
            step();
            steps++;
        end
        in_valid_i = 1'b0;
        check("stream_back_to_back", 32'(steps), 32'd8);
        for (int i = 0; i < 20 && out_fires < 8; i++) step();
        check("stream_count", 32'(out_fires), 32'd8);
        check("stream_consecutive", 32'(last_out_cyc - first_out_cyc), 32'd7);
        check("stream_latency", 32'(first_out_cyc), 32'(first_acc_edge + DEPTH - 1));

        // Backpressure fill with 0xA0..0xA5.
        out_ready_i = 1'b0;
        acc_cnt = 0;
        out_fires = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'hA0 + 32'(acc_cnt);
            step();
        end
        check("bp_accepted", 32'(acc_cnt), 32'(2 * DEPTH));
        check("bp_in_ready", 32'(in_ready_o), 32'd0);
        check("bp_out_valid", 32'(out_valid_o), 32'd1);
        check("bp_out_data", out_data_o, 32'hA0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 40 && (out_fires < 6 || exp_q.size() != 0); i++) begin
            in_valid_i = (acc_cnt < 6);
            in_data_i  = 32'hA0 + 32'(acc_cnt);
            step();
        end
        in_valid_i = 1'b0;
        check("bp_total_out", 32'(out_fires), 32'd6);
        check("bp_no_gap", 32'(last_out_cyc - first_out_cyc), 32'd5);

        // Flush with a same-cycle input beat of 0xFF.
        out_ready_i = 1'b0;
        acc_cnt = 0;
        out_fires = 0;
        for (int i = 0; i < 10 && acc_cnt < 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h11 * 32'(acc_cnt + 1);
            step();
        end
        check("flush_preload", 32'(acc_cnt), 32'd3);
        in_valid_i = 1'b1;
        in_data_i  = 32'hFF;
        flush_i    = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("flush_out_valid", 32'(out_valid_o), 32'd0);
        check("flush_in_ready", 32'(in_ready_o), 32'd1);
        out_ready_i = 1'b1;
        repeat (8) step();
        check("flush_nothing_out", 32'(out_fires), 32'd0);

        // Random handshake against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            int pv = 30 + 20 * ((i / 1000) % 3);
            int pr = 90 - 30 * ((i / 700) % 3);
            in_valid_i  = ($urandom_range(0, 99) < pv);
            in_data_i   = in_valid_i ? $urandom : 'x;
            out_ready_i = ($urandom_range(0, 99) < pr);
            flush_i     = ($urandom_range(0, 399) == 0);
            step();
        end
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        repeat (2) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_out_valid", 32'(out_valid_o), 32'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
